// File: rtl/sound_pkg.sv
// Shared sound codes, sequencer state encoding and the code-priority helper.
package sound_pkg;

  localparam logic [1:0] SND_OFF        = 2'b00;
  localparam logic [1:0] SND_ROUND_WIN  = 2'b01;
  localparam logic [1:0] SND_ROUND_LOSE = 2'b10;
  localparam logic [1:0] SND_VICTORY    = 2'b11;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  // Ranking is not numeric code order: lose ranks below win.
  function automatic logic [1:0] prio(input logic [1:0] code);
    case (code)
      SND_ROUND_LOSE: prio = 2'd1;
      SND_ROUND_WIN:  prio = 2'd2;
      SND_VICTORY:    prio = 2'd3;
      default:        prio = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sound_event_arbiter.sv
// Picks the highest incoming game event and holds one pending event (keep-highest).
module sound_event_arbiter
  import sound_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       round_won_i,
  input  logic       round_lost_i,
  input  logic       game_won_i,
  input  logic       store_i,
  input  logic       take_i,
  output logic [1:0] evt_code_o,
  output logic [1:0] merged_code_o,
  output logic [1:0] pend_code_o,
  output logic [1:0] pend_code_d_o
);

  logic [1:0] pend_q, pend_d;

  always_comb begin
    evt_code_o = SND_OFF;
    if (game_won_i)        evt_code_o = SND_VICTORY;
    else if (round_won_i)  evt_code_o = SND_ROUND_WIN;
    else if (round_lost_i) evt_code_o = SND_ROUND_LOSE;
  end

  // Ties keep the stored event; an empty slot (OFF) ranks lowest.
  assign merged_code_o = (prio(evt_code_o) > prio(pend_q)) ? evt_code_o : pend_q;

  always_comb begin
    pend_d = pend_q;
    if (take_i)       pend_d = SND_OFF;
    else if (store_i) pend_d = merged_code_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= SND_OFF;
    else     pend_q <= pend_d;
  end

  assign pend_code_o   = pend_q;
  assign pend_code_d_o = pend_d;

endmodule

// File: rtl/sound_sequencer.sv
// Turns one-cycle game events into timed sound bursts followed by a silent gap.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int ROUND_CYCLES   = 50_000_000,
  parameter int VICTORY_CYCLES = 150_000_000,
  parameter int GAP_CYCLES     = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       round_won,
  input  logic       round_lost,
  input  logic       game_won,
  input  logic       mute,
  output logic [1:0] sound_control,
  output logic       busy
);

  localparam int MAX_RV = (ROUND_CYCLES > VICTORY_CYCLES) ? ROUND_CYCLES : VICTORY_CYCLES;
  localparam int MAXC   = (MAX_RV > GAP_CYCLES) ? MAX_RV : GAP_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] ROUND_LEN = CW'(ROUND_CYCLES - 1);
  localparam logic [CW-1:0] VIC_LEN   = CW'(VICTORY_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LEN   = CW'(GAP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    snd_q, snd_d;
  logic          busy_q, busy_d;
  logic          store, take;
  logic [1:0]    evt_code, merged_code, pend_code, pend_code_d;

  sound_event_arbiter u_arb (
    .clk           (clk),
    .rst           (rst),
    .round_won_i   (round_won),
    .round_lost_i  (round_lost),
    .game_won_i    (game_won),
    .store_i       (store),
    .take_i        (take),
    .evt_code_o    (evt_code),
    .merged_code_o (merged_code),
    .pend_code_o   (pend_code),
    .pend_code_d_o (pend_code_d)
  );

  function automatic logic [CW-1:0] len_of(input logic [1:0] code);
    len_of = (code == SND_VICTORY) ? VIC_LEN : ROUND_LEN;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    store   = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt_code != SND_OFF) begin
          state_d = PLAY;
          code_d  = evt_code;
          cnt_d   = len_of(evt_code);
        end else if (pend_code != SND_OFF) begin
          state_d = PLAY;
          code_d  = pend_code;
          cnt_d   = len_of(pend_code);
          take    = 1'b1;
        end
      end
      PLAY: begin
        if (evt_code != SND_OFF && prio(evt_code) > prio(code_q)) begin
          code_d = evt_code;
          cnt_d  = len_of(evt_code);
        end else begin
          store = (evt_code != SND_OFF);
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LEN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      GAP: begin
        // An event arriving on the last gap cycle is eligible to play right away.
        if (cnt_q == '0) begin
          if (merged_code != SND_OFF) begin
            state_d = PLAY;
            code_d  = merged_code;
            cnt_d   = len_of(merged_code);
            take    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          store = (evt_code != SND_OFF);
        end
      end
      default: state_d = IDLE;
    endcase
    snd_d  = (!mute && state_d == PLAY) ? code_d : SND_OFF;
    busy_d = (state_d != IDLE) || (pend_code_d != SND_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= SND_OFF;
      snd_q   <= SND_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      snd_q   <= snd_d;
      busy_q  <= busy_d;
    end
  end

  assign sound_control = snd_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: per-cycle expectations from a burst/gap model, checked by a negedge monitor.
module tb_sound_sequencer;
  localparam int RC = 8, VC = 16, GC = 3;

  logic clk = 1'b0;
  logic rst, rw, rl, gw, mute;
  logic [1:0] sc;
  logic busy;

  always #5 clk = ~clk;

  sound_sequencer #(.ROUND_CYCLES(RC), .VICTORY_CYCLES(VC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .round_won(rw), .round_lost(rl), .game_won(gw),
    .mute(mute), .sound_control(sc), .busy(busy)
  );

  typedef struct packed { logic [1:0] snd; logic bsy; } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0, cyc = 0;

  // Model: what is audible now, how many cycles of it remain, and the one queued event.
  int m_phase;             // 0 silent-idle, 1 sounding, 2 gap
  int m_left;
  logic [1:0] m_cur, m_pend;

  function automatic int rank(input logic [1:0] c);
    case (c)
      2'b10: return 1;
      2'b01: return 2;
      2'b11: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int blen(input logic [1:0] c);
    return (c == 2'b11) ? VC : RC;
  endfunction

  task automatic start_burst(input logic [1:0] c);
    m_phase = 1; m_cur = c; m_left = blen(c);
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_cur = 2'b00; m_pend = 2'b00;
  endtask

  // Drive one cycle of inputs (called half a cycle before the sampling edge).
  task automatic step(input bit w, input bit l, input bit g, input bit m);
    logic [1:0] e;
    exp_t x;
    rw = w; rl = l; gw = g; mute = m;
    e = g ? 2'b11 : w ? 2'b01 : l ? 2'b10 : 2'b00;
    case (m_phase)
      0: begin
        if (e != 2'b00) start_burst(e);
        else if (m_pend != 2'b00) begin start_burst(m_pend); m_pend = 2'b00; end
      end
      1: begin
        if (rank(e) > rank(m_cur)) start_burst(e);
        else begin
          if (rank(e) > rank(m_pend)) m_pend = e;
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_left = GC; end
        end
      end
      default: begin
        if (rank(e) > rank(m_pend)) m_pend = e;
        m_left--;
        if (m_left == 0) begin
          if (m_pend != 2'b00) begin start_burst(m_pend); m_pend = 2'b00; end
          else m_phase = 0;
        end
      end
    endcase
    x.snd = (!m && m_phase == 1) ? m_cur : 2'b00;
    x.bsy = (m_phase != 0) || (m_pend != 2'b00);
    q.push_back(x);
    @(negedge clk); #1;
    rw = 1'b0; rl = 1'b0; gw = 1'b0;
  endtask

  task automatic idle(input int n, input bit m = 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, m);
  endtask

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {snd,busy}=%b, expected %b", nm, got, exp);
    end
  endtask

  task automatic async_reset(input string nm);
    rw = 1'b0; rl = 1'b0; gw = 1'b0;
    rst = 1'b1;
    #1 chk(nm, {sc, busy}, 3'b000);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t x;
    cyc++;
    if (q.size() > 0) begin
      x = q.pop_front();
      n_checks++;
      if (sc !== x.snd || busy !== x.bsy) begin
        n_fail++;
        $display("FAIL seq@%0d: sound_control=%b busy=%b, expected sound_control=%b busy=%b",
                 cyc, sc, busy, x.snd, x.bsy);
      end
    end
  end

  initial begin
    rst = 1'b1; rw = 1'b0; rl = 1'b0; gw = 1'b0; mute = 1'b0;
    model_reset();
    #1 chk("reset_state", {sc, busy}, 3'b000);
    @(negedge clk); #1;
    rst = 1'b0;
    idle(2);

    // single round win
    step(1, 0, 0, 0); idle(14);
    // lose + victory together: only victory plays
    step(0, 1, 1, 0); idle(22);
    // victory preempts a lose burst
    step(0, 1, 0, 0); idle(3); step(0, 0, 1, 0); idle(22);
    // pending keep-highest: lose replaced by win
    step(1, 0, 0, 0); idle(2); step(0, 1, 0, 0); idle(1); step(1, 0, 0, 0); idle(20);
    // mute during a burst, released mid-burst
    step(1, 0, 0, 1); idle(4, 1'b1); idle(12);
    // event arrives on the final gap cycle
    step(1, 0, 0, 0); idle(10); step(0, 1, 0, 0); idle(14);
    // async reset mid-burst with an event pending
    step(1, 0, 0, 0); idle(2); step(0, 1, 0, 0);
    async_reset("reset_midburst");
    idle(30);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) async_reset("reset_random");
      else step($urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1, "timeout");
  end

endmodule
